// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, prefetches 16-bit instructions with their PC into a small FIFO.
// Optional performance counters are enabled by defining INSTR_FETCH_PERF_EN.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 4,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'h9
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic              out_valid,
    output logic [15:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [15:0]       perf_fetched,
    output logic [15:0]       perf_stall
`endif
);

    localparam int unsigned       PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned       CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              halted_q, halted_d;
    logic [15:0]       head_instr_q, head_instr_d;
    logic [ADDR_W-1:0] head_pc_q, head_pc_d;

    logic [15:0]       mem_instr [DEPTH];
    logic [ADDR_W-1:0] mem_pc    [DEPTH];

    logic pop;
    logic push;

    assign pop  = (count_q != '0) && out_ready;
    assign push = !redirect_valid && !halted_q && ((count_q != FULL_CNT) || pop);

    always_comb begin
        pc_d         = pc_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        halted_d     = halted_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            halted_d = 1'b0;
        end else begin
            if (push) begin
                pc_d     = pc_q + PC_ONE;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                if (imem_data[15:12] == HALT_OP) halted_d = 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
        // Head is registered so it holds its last value once the FIFO drains;
        // when the new head is the entry being written this edge, bypass the array.
        if (count_d != '0) begin
            if (push && (rd_ptr_d == wr_ptr_q)) begin
                head_instr_d = imem_data;
                head_pc_d    = pc_q;
            end else begin
                head_instr_d = mem_instr[rd_ptr_d];
                head_pc_d    = mem_pc[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            halted_q     <= 1'b0;
            head_instr_q <= '0;
            head_pc_q    <= '0;
        end else begin
            pc_q         <= pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            halted_q     <= halted_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_instr[wr_ptr_q] <= imem_data;
            mem_pc[wr_ptr_q]    <= pc_q;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = (count_q != '0);
    assign out_instr = head_instr_q;
    assign out_pc    = head_pc_q;
    assign halted    = halted_q;

`ifdef INSTR_FETCH_PERF_EN
    logic [15:0] fetched_q;
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else begin
            if (push && (fetched_q != '1)) fetched_q <= fetched_q + 16'd1;
            if (!halted_q && !redirect_valid && (count_q == FULL_CNT) && !pop && (stall_q != '1))
                stall_q <= stall_q + 16'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: streaming, backpressure, redirect, halt, wrap, reset.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  imem_addr;
    logic [15:0] imem_data;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [3:0]  out_pc;
    logic        out_ready;
    logic        redirect_valid;
    logic [3:0]  redirect_pc;
    logic        halted;
`ifdef INSTR_FETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_stall;
`endif

    logic [15:0] imem [16];
    int passed = 0;
    int total  = 0;

    assign imem_data = imem[imem_addr];

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(4), .DEPTH(4), .RESET_PC(4'h0), .HALT_OP(4'h9)) dut (
        .clk(clk),
        .rst(rst),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .out_ready(out_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .halted(halted)
`ifdef INSTR_FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall(perf_stall)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic init_imem;
        for (int i = 0; i < 16; i++) imem[i] = {8'h10, 4'(i), 4'hA};
        imem[0] = 16'h1105;
        imem[1] = 16'h1216;
        imem[2] = 16'h0312;
    endtask

    task automatic do_reset;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 4'h0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 4'h0;
        tick(); tick();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else passed++;
        total++; if (out_pc !== 4'h0) $display("FAIL reset_pc: got %h expected 0", out_pc); else passed++;
        total++; if (out_instr !== 16'h0) $display("FAIL reset_instr: got %h expected 0000", out_instr); else passed++;
        total++; if (imem_addr !== 4'h0) $display("FAIL reset_addr: got %h expected 0", imem_addr); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b expected 0", halted); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_stream;
        logic [15:0] exp_i [4];
        exp_i[0] = 16'h1105; exp_i[1] = 16'h1216; exp_i[2] = 16'h0312; exp_i[3] = 16'h103A;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (out_valid !== 1'b1) $display("FAIL stream_valid%0d: got %b expected 1", k, out_valid); else passed++;
            total++; if (out_pc !== 4'(k)) $display("FAIL stream_pc%0d: got %h expected %h", k, out_pc, 4'(k)); else passed++;
            total++; if (out_instr !== exp_i[k]) $display("FAIL stream_instr%0d: got %h expected %h", k, out_instr, exp_i[k]); else passed++;
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] exp_i [5];
        exp_i[0] = 16'h1105; exp_i[1] = 16'h1216; exp_i[2] = 16'h0312; exp_i[3] = 16'h103A; exp_i[4] = 16'h104A;
        do_reset();
        for (int k = 0; k < 10; k++) tick();
        total++; if (imem_addr !== 4'h4) $display("FAIL full_addr: got %h expected 4", imem_addr); else passed++;
        total++; if (out_valid !== 1'b1) $display("FAIL full_valid: got %b expected 1", out_valid); else passed++;
        total++; if (out_pc !== 4'h0) $display("FAIL full_head_pc: got %h expected 0", out_pc); else passed++;
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++; if (out_pc !== 4'(k)) $display("FAIL drain_pc%0d: got %h expected %h", k, out_pc, 4'(k)); else passed++;
            total++; if (out_instr !== exp_i[k]) $display("FAIL drain_instr%0d: got %h expected %h", k, out_instr, exp_i[k]); else passed++;
            total++; if (out_valid !== 1'b1) $display("FAIL drain_valid%0d: got %b expected 1", k, out_valid); else passed++;
        end
    endtask

    task automatic test_redirect;
        do_reset();
        tick(); tick(); tick();
        total++; if (imem_addr !== 4'h3) $display("FAIL redir_pre_addr: got %h expected 3", imem_addr); else passed++;
        redirect_valid = 1'b1; redirect_pc = 4'hA;
        tick();
        redirect_valid = 1'b0; out_ready = 1'b1;
        total++; if (out_valid !== 1'b0) $display("FAIL redir_flush_valid: got %b expected 0", out_valid); else passed++;
        total++; if (imem_addr !== 4'hA) $display("FAIL redir_addr: got %h expected a", imem_addr); else passed++;
        total++; if (out_pc !== 4'h0) $display("FAIL redir_hold_pc: got %h expected 0", out_pc); else passed++;
        tick();
        total++; if (out_valid !== 1'b1) $display("FAIL redir_valid: got %b expected 1", out_valid); else passed++;
        total++; if (out_pc !== 4'hA) $display("FAIL redir_pc: got %h expected a", out_pc); else passed++;
        total++; if (out_instr !== 16'h10AA) $display("FAIL redir_instr: got %h expected 10aa", out_instr); else passed++;
        tick();
        total++; if (out_pc !== 4'hB) $display("FAIL redir_next_pc: got %h expected b", out_pc); else passed++;
    endtask

    task automatic test_halt;
        imem[2] = 16'h9000;
        do_reset();
        out_ready = 1'b1;
        tick(); tick();
        total++; if (halted !== 1'b0) $display("FAIL halt_early: got %b expected 0", halted); else passed++;
        tick();
        total++; if (halted !== 1'b1) $display("FAIL halt_set: got %b expected 1", halted); else passed++;
        total++; if (out_pc !== 4'h2) $display("FAIL halt_pc: got %h expected 2", out_pc); else passed++;
        total++; if (out_instr !== 16'h9000) $display("FAIL halt_instr: got %h expected 9000", out_instr); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL halt_drained: got %b expected 0", out_valid); else passed++;
        total++; if (imem_addr !== 4'h3) $display("FAIL halt_addr: got %h expected 3", imem_addr); else passed++;
        tick();
        total++; if (imem_addr !== 4'h3) $display("FAIL halt_addr_hold: got %h expected 3", imem_addr); else passed++;
        total++; if (halted !== 1'b1) $display("FAIL halt_sticky: got %b expected 1", halted); else passed++;
        redirect_valid = 1'b1; redirect_pc = 4'h0;
        tick();
        redirect_valid = 1'b0;
        total++; if (halted !== 1'b0) $display("FAIL halt_clear: got %b expected 0", halted); else passed++;
        tick();
        total++; if (out_valid !== 1'b1) $display("FAIL halt_restart_valid: got %b expected 1", out_valid); else passed++;
        total++; if (out_pc !== 4'h0) $display("FAIL halt_restart_pc: got %h expected 0", out_pc); else passed++;
        imem[2] = 16'h0312;
    endtask

    task automatic test_wrap_and_reset;
        do_reset();
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 4'hE;
        tick();
        redirect_valid = 1'b0;
        tick();
        total++; if (out_pc !== 4'hE) $display("FAIL wrap_pc14: got %h expected e", out_pc); else passed++;
        tick();
        total++; if (out_pc !== 4'hF) $display("FAIL wrap_pc15: got %h expected f", out_pc); else passed++;
        total++; if (imem_addr !== 4'h0) $display("FAIL wrap_addr: got %h expected 0", imem_addr); else passed++;
        tick();
        total++; if (out_pc !== 4'h0) $display("FAIL wrap_pc0: got %h expected 0", out_pc); else passed++;
        total++; if (out_instr !== 16'h1105) $display("FAIL wrap_instr: got %h expected 1105", out_instr); else passed++;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        total++; if (imem_addr !== 4'h4) $display("FAIL prerst_addr: got %h expected 4", imem_addr); else passed++;
        rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 4'h5;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", out_valid); else passed++;
        total++; if (imem_addr !== 4'h0) $display("FAIL midrst_addr: got %h expected 0", imem_addr); else passed++;
        rst = 1'b0; redirect_valid = 1'b0;
    endtask

`ifdef INSTR_FETCH_PERF_EN
    task automatic test_perf;
        do_reset();
        out_ready = 1'b1;
        tick(); tick(); tick();
        out_ready = 1'b0;
        tick(); tick(); tick();
        total++; if (perf_fetched !== 16'd6) $display("FAIL perf_fetched: got %0d expected 6", perf_fetched); else passed++;
        total++; if (perf_stall !== 16'd0) $display("FAIL perf_stall_pre: got %0d expected 0", perf_stall); else passed++;
        tick(); tick(); tick();
        total++; if (perf_fetched !== 16'd6) $display("FAIL perf_fetched_hold: got %0d expected 6", perf_fetched); else passed++;
        total++; if (perf_stall !== 16'd3) $display("FAIL perf_stall: got %0d expected 3", perf_stall); else passed++;
    endtask
`endif

    initial begin
        init_imem();
        rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 4'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap_and_reset();
`ifdef INSTR_FETCH_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
